// File: rtl/maze_map_renderer.sv
// maze_map_renderer
//   Holds {treasure, explored} flags for every cell of a GRID_W x GRID_H maze
//   and the robot's current cell. Position and treasure updates arrive over a
//   valid/ready port. Each VGA pixel coordinate is turned into an RGB332
//   colour two clock cycles after it is presented.
//
// Ports
//   CLOCK           25 MHz pixel clock, rising edge
//   RESET           synchronous, active-high; restarts the clearing sweep
//   PIXEL_X/Y       pixel coordinate from the VGA driver
//   PIXEL_COLOR     colour for the coordinate sampled two edges earlier
//   UPD_VALID/READY update handshake (see below)
//   UPD_OP          0 MOVE, 1 TREASURE, 2 CLEAR_ALL, 3 reserved
//   UPD_X/UPD_Y     target cell of the update
//   CUR_VALID/X/Y   robot position
//   EXPLORED_COUNT  number of cells whose explored flag is set
//   UPD_ERR         sticky flag for rejected updates, cleared only by RESET
//   DBG_STATE       1 = IDLE, 0 = CLEAR (sweep in progress)
//
// Handshake: an update is taken on a rising edge where UPD_VALID and
// UPD_READY are both high. UPD_READY depends only on the FSM state (high in
// IDLE), never on UPD_VALID, so one update can be taken every cycle in IDLE.
module maze_map_renderer #(
  parameter int         GRID_W     = 4,
  parameter int         GRID_H     = 5,
  parameter int         CELL_SHIFT = 6,
  parameter logic [7:0] C_UNEXP    = 8'hFF,
  parameter logic [7:0] C_EXPL     = 8'hF3,
  parameter logic [7:0] C_CUR      = 8'h00,
  parameter logic [7:0] C_TREAS    = 8'h9B,
  parameter logic [7:0] C_LINE     = 8'h49,
  parameter logic [7:0] C_BG       = 8'h00
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [9:0] PIXEL_X,
  input  logic [9:0] PIXEL_Y,
  output logic [7:0] PIXEL_COLOR,
  input  logic       UPD_VALID,
  output logic       UPD_READY,
  input  logic [1:0] UPD_OP,
  input  logic [2:0] UPD_X,
  input  logic [2:0] UPD_Y,
  output logic       CUR_VALID,
  output logic [2:0] CUR_X,
  output logic [2:0] CUR_Y,
  output logic [6:0] EXPLORED_COUNT,
  output logic       UPD_ERR,
  output logic       DBG_STATE
);

  localparam logic [1:0]  OP_MOVE   = 2'd0;
  localparam logic [1:0]  OP_TREAS  = 2'd1;
  localparam logic [1:0]  OP_CLEAR  = 2'd2;
  localparam logic [1:0]  OP_NOP    = 2'd3;
  localparam logic [5:0]  GW6       = 6'(GRID_W);
  localparam logic [3:0]  GW4       = 4'(GRID_W);
  localparam logic [3:0]  GH4       = 4'(GRID_H);
  localparam logic [5:0]  LAST_ADDR = 6'(GRID_W * GRID_H - 1);
  localparam logic [10:0] X_LIM     = 11'(GRID_W << CELL_SHIFT);
  localparam logic [10:0] Y_LIM     = 11'(GRID_H << CELL_SHIFT);
  localparam logic [9:0]  LOW_MASK  = 10'((1 << CELL_SHIFT) - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [5:0] sweep_addr, sweep_nxt;

  // Sized to the full 6-bit address space so every index is in range;
  // only the first GRID_W*GRID_H entries are ever used.
  logic [1:0] mem [64];

  logic       mem_we;
  logic [5:0] mem_waddr;
  logic [1:0] mem_wdata;
  logic [1:0] mem_upd;
  logic [5:0] upd_idx;
  logic       upd_fire;
  logic       upd_bad;

  assign UPD_READY = (state == S_IDLE);
  assign DBG_STATE = (state == S_IDLE);
  assign upd_fire  = UPD_VALID && UPD_READY;
  assign upd_idx   = {3'b000, UPD_Y} * GW6 + {3'b000, UPD_X};
  assign mem_upd   = mem[upd_idx];
  // CLEAR_ALL ignores the coordinates, so they cannot make it an error.
  assign upd_bad   = (UPD_OP == OP_NOP) ||
                     ((UPD_OP != OP_CLEAR) &&
                      (({1'b0, UPD_X} >= GW4) || ({1'b0, UPD_Y} >= GH4)));

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= S_CLEAR;
      sweep_addr <= 6'd0;
    end else begin
      state      <= state_nxt;
      sweep_addr <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_addr;
    mem_we    = 1'b0;
    mem_waddr = sweep_addr;
    mem_wdata = 2'b00;
    case (state)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (sweep_addr == LAST_ADDR) state_nxt = S_IDLE;
        else                         sweep_nxt = sweep_addr + 6'd1;
      end
      S_IDLE: begin
        if (upd_fire && !upd_bad) begin
          case (UPD_OP)
            OP_MOVE: begin
              mem_we    = 1'b1;
              mem_waddr = upd_idx;
              mem_wdata = {mem_upd[1], 1'b1};
            end
            OP_TREAS: begin
              mem_we    = 1'b1;
              mem_waddr = upd_idx;
              mem_wdata = {1'b1, mem_upd[0]};
            end
            default: begin
              state_nxt = S_CLEAR;
              sweep_nxt = 6'd0;
            end
          endcase
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (mem_we && !RESET) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      CUR_VALID      <= 1'b0;
      CUR_X          <= 3'd0;
      CUR_Y          <= 3'd0;
      EXPLORED_COUNT <= 7'd0;
      UPD_ERR        <= 1'b0;
    end else if (upd_fire) begin
      if (upd_bad) begin
        UPD_ERR <= 1'b1;
      end else if (UPD_OP == OP_MOVE) begin
        CUR_VALID <= 1'b1;
        CUR_X     <= UPD_X;
        CUR_Y     <= UPD_Y;
        if (!mem_upd[0]) EXPLORED_COUNT <= EXPLORED_COUNT + 7'd1;
      end else if (UPD_OP == OP_CLEAR) begin
        CUR_VALID      <= 1'b0;
        EXPLORED_COUNT <= 7'd0;
      end
    end
  end

  // Render stage 1: classify the pixel and form the cell index.
  logic       pix_off, pix_line;
  logic [2:0] pix_cx, pix_cy;
  logic [5:0] pix_idx;
  logic       s1_off, s1_line;
  logic [2:0] s1_cx, s1_cy;
  logic [5:0] s1_idx;

  assign pix_off  = ({1'b0, PIXEL_X} >= X_LIM) || ({1'b0, PIXEL_Y} >= Y_LIM);
  assign pix_line = ((PIXEL_X & LOW_MASK) == 10'd0) ||
                    ((PIXEL_Y & LOW_MASK) == 10'd0);
  assign pix_cx   = PIXEL_X[CELL_SHIFT +: 3];
  assign pix_cy   = PIXEL_Y[CELL_SHIFT +: 3];
  assign pix_idx  = {3'b000, pix_cy} * GW6 + {3'b000, pix_cx};

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      s1_off  <= 1'b1;
      s1_line <= 1'b0;
      s1_cx   <= 3'd0;
      s1_cy   <= 3'd0;
      s1_idx  <= 6'd0;
    end else begin
      s1_off  <= pix_off;
      s1_line <= pix_line;
      s1_cx   <= pix_cx;
      s1_cy   <= pix_cy;
      s1_idx  <= pix_idx;
    end
  end

  // Render stage 2: memory read plus priority colouring. A write to the same
  // cell on this edge is not seen until the next pixel (old value returned).
  logic [1:0] rd_flags;
  assign rd_flags = mem[s1_idx];

  always_ff @(posedge CLOCK) begin
    if (RESET)                     PIXEL_COLOR <= C_BG;
    else if (s1_off)               PIXEL_COLOR <= C_BG;
    else if (s1_line)              PIXEL_COLOR <= C_LINE;
    else if (state == S_CLEAR)     PIXEL_COLOR <= C_UNEXP;
    else if (CUR_VALID && s1_cx == CUR_X && s1_cy == CUR_Y)
                                   PIXEL_COLOR <= C_CUR;
    else if (rd_flags[1])          PIXEL_COLOR <= C_TREAS;
    else if (rd_flags[0])          PIXEL_COLOR <= C_EXPL;
    else                           PIXEL_COLOR <= C_UNEXP;
  end

endmodule

// File: tb/tb_maze_map_renderer.sv
// Directed bench for maze_map_renderer with default 4x5 grid, 64 px cells.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_maze_map_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] pixel_color;
  logic       upd_valid, upd_ready;
  logic [1:0] upd_op;
  logic [2:0] upd_x, upd_y;
  logic       cur_valid;
  logic [2:0] cur_x, cur_y;
  logic [6:0] explored_count;
  logic       upd_err;
  logic       dbg_state;

  int total = 0;
  int bad   = 0;
  int n;

  always #20 clk = ~clk;

  maze_map_renderer dut (
    .CLOCK(clk), .RESET(rst),
    .PIXEL_X(pixel_x), .PIXEL_Y(pixel_y), .PIXEL_COLOR(pixel_color),
    .UPD_VALID(upd_valid), .UPD_READY(upd_ready), .UPD_OP(upd_op),
    .UPD_X(upd_x), .UPD_Y(upd_y),
    .CUR_VALID(cur_valid), .CUR_X(cur_x), .CUR_Y(cur_y),
    .EXPLORED_COUNT(explored_count), .UPD_ERR(upd_err),
    .DBG_STATE(dbg_state)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a pixel and compare the colour two edges later.
  task automatic pix_check(input string tag, input int x, input int y,
                           input logic [7:0] exp);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    repeat (2) @(negedge clk);
    check_val(tag, pixel_color, exp);
  endtask

  // Offer one update; returns how many cycles it waited for READY.
  task automatic do_upd(input logic [1:0] o, input logic [2:0] x,
                        input logic [2:0] y, output int waits);
    upd_op = o; upd_x = x; upd_y = y; upd_valid = 1'b1;
    waits = 0;
    while (!upd_ready && waits < 60) begin
      @(negedge clk);
      waits++;
    end
    if (!upd_ready) check_val("upd_timeout", upd_ready, 1);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  // Count edges until READY rises (bounded).
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!upd_ready && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_op = 2'd0; upd_x = 3'd0; upd_y = 3'd0;
    pixel_x = 10'd0; pixel_y = 10'd0;
    repeat (3) @(negedge clk);
    check_val("rst_color", pixel_color, 8'h00);
    check_val("rst_ready", upd_ready, 0);
    check_val("rst_cur_valid", cur_valid, 0);
    check_val("rst_cur", {cur_x, cur_y}, 0);
    check_val("rst_count", explored_count, 0);
    check_val("rst_err", upd_err, 0);
    rst = 1'b0;
    wait_ready(n);
    check_val("sweep_len_rst", n, 20);

    // Empty map rendering and boundaries.
    pix_check("pix_00_white", 10, 10, 8'hFF);
    pix_check("pix_offx", 300, 10, 8'h00);
    pix_check("pix_line_x", 64, 10, 8'h49);
    pix_check("pix_line_y", 100, 128, 8'h49);
    pix_check("pix_offy", 10, 320, 8'h00);
    pix_check("pix_lastin", 255, 319, 8'hFF);
    // Two-cycle lag: new pixel (64,10) after (255,319).
    pixel_x = 10'd64; pixel_y = 10'd10;
    @(negedge clk);
    check_val("lag_1", pixel_color, 8'hFF);
    pixel_x = 10'd10; pixel_y = 10'd10;
    @(negedge clk);
    check_val("lag_2", pixel_color, 8'h49);
    @(negedge clk);
    check_val("lag_3", pixel_color, 8'hFF);

    // Moves.
    do_upd(2'd0, 3'd0, 3'd0, n);
    check_val("move00_count", explored_count, 1);
    do_upd(2'd0, 3'd1, 3'd0, n);
    check_val("move10_count", explored_count, 2);
    do_upd(2'd0, 3'd1, 3'd0, n);
    check_val("move10_again", explored_count, 2);
    check_val("cur_after_moves", {cur_valid, cur_x, cur_y}, {1'b1, 3'd1, 3'd0});
    pix_check("pix_expl", 10, 10, 8'hF3);
    pix_check("pix_cur", 70, 10, 8'h00);

    // Treasure.
    do_upd(2'd1, 3'd2, 3'd3, n);
    check_val("treas_count", explored_count, 2);
    check_val("treas_cur", {cur_x, cur_y}, {3'd1, 3'd0});
    pix_check("pix_treas", 130, 200, 8'h9B);
    do_upd(2'd0, 3'd2, 3'd3, n);
    check_val("move23_count", explored_count, 3);
    pix_check("pix_treas_cur", 130, 200, 8'h00);
    do_upd(2'd0, 3'd0, 3'd0, n);
    check_val("move00b_count", explored_count, 3);
    pix_check("pix_treas_back", 130, 200, 8'h9B);

    // Out-of-range updates.
    check_val("err_before", upd_err, 0);
    do_upd(2'd0, 3'd4, 3'd0, n);
    check_val("oor_x_wait", n, 0);
    check_val("oor_x_err", upd_err, 1);
    check_val("oor_x_count", explored_count, 3);
    do_upd(2'd0, 3'd0, 3'd5, n);
    check_val("oor_y_wait", n, 0);
    check_val("oor_y_ready", upd_ready, 1);
    check_val("oor_y_count", explored_count, 3);
    check_val("oor_cur", {cur_x, cur_y}, {3'd0, 3'd0});

    // CLEAR_ALL with a MOVE held pending through the sweep.
    do_upd(2'd2, 3'd0, 3'd0, n);
    check_val("clr_ready", upd_ready, 0);
    check_val("clr_cur_valid", cur_valid, 0);
    check_val("clr_count", explored_count, 0);
    upd_op = 2'd0; upd_x = 3'd3; upd_y = 3'd4; upd_valid = 1'b1;
    wait_ready(n);
    check_val("sweep_len_clr", n, 20);
    check_val("held_not_taken", explored_count, 0);
    @(negedge clk);
    upd_valid = 1'b0;
    check_val("held_taken_once", explored_count, 1);
    check_val("held_cur", {cur_valid, cur_x, cur_y}, {1'b1, 3'd3, 3'd4});
    pix_check("clr_pix00", 10, 10, 8'hFF);
    pix_check("clr_pix23", 130, 200, 8'hFF);
    pix_check("clr_pix10", 70, 10, 8'hFF);
    pix_check("clr_pix34_cur", 200, 300, 8'h00);

    // Reset in the middle of a sweep.
    do_upd(2'd2, 3'd0, 3'd0, n);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_err", upd_err, 0);
    rst = 1'b0;
    wait_ready(n);
    check_val("sweep_len_midrst", n, 20);
    check_val("midrst_count", explored_count, 0);
    check_val("midrst_cur_valid", cur_valid, 0);
    pix_check("midrst_pix34", 200, 300, 8'hFF);
    do_upd(2'd3, 3'd1, 3'd1, n);
    check_val("nop_err", upd_err, 1);
    check_val("nop_count", explored_count, 0);
    do_upd(2'd0, 3'd3, 3'd4, n);
    check_val("post_move_count", explored_count, 1);
    pix_check("post_pix34", 200, 300, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
